// File: rtl/spi_slave_if.sv
// Bus bundle for the SPI slave: parallel TX/RX word ports on the system
// clock side plus the four SPI pins and the MISO pad enable.
interface spi_slave_if #(
  parameter int XFER_SIZE = 32
);
  logic [XFER_SIZE-1:0] i_tx_data;
  logic                 o_tx_load;
  logic [XFER_SIZE-1:0] o_rx_data;
  logic                 o_rx_vld;
  logic                 o_xfer_abort;
  logic                 o_busy;
  logic                 i_slave_sclk;
  logic                 i_slave_cs_n;
  logic                 i_slave_mosi;
  logic                 o_slave_miso;
  logic                 o_slave_miso_oe;

  // Seen from the slave endpoint.
  modport slave (
    input  i_tx_data, i_slave_sclk, i_slave_cs_n, i_slave_mosi,
    output o_tx_load, o_rx_data, o_rx_vld, o_xfer_abort, o_busy,
           o_slave_miso, o_slave_miso_oe
  );

  // Seen from whoever drives the pins and supplies TX words.
  modport master (
    output i_tx_data, i_slave_sclk, i_slave_cs_n, i_slave_mosi,
    input  o_tx_load, o_rx_data, o_rx_vld, o_xfer_abort, o_busy,
           o_slave_miso, o_slave_miso_oe
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, fixed word size. SCLK, CS_N and MOSI are
// oversampled on i_sys_clk; every flop runs on the system clock.
module spi_slave #(
  parameter int XFER_SIZE   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst_n,
  spi_slave_if.slave bus
);
  localparam int XFER_CNT_WIDTH = $clog2(XFER_SIZE);
  localparam logic [XFER_CNT_WIDTH-1:0] LAST_BIT = XFER_CNT_WIDTH'(XFER_SIZE - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  // Synchronizer chains and edge-detect history.
  logic [SYNC_STAGES-1:0] sclk_sync_d, sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_d,   cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_d, mosi_sync_q;
  logic                   sclk_hist_d, sclk_hist_q;
  logic                   cs_hist_d,   cs_hist_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  // Protocol state.
  state_e                    state_d,     state_q;
  logic [XFER_CNT_WIDTH-1:0] bit_cnt_d,   bit_cnt_q;
  logic [XFER_SIZE-1:0]      tx_sr_d,     tx_sr_q;
  logic [XFER_SIZE-2:0]      rx_sr_d,     rx_sr_q;
  logic [XFER_SIZE-1:0]      rx_data_d,   rx_data_q;
  logic                      word_done_d, word_done_q;
  logic                      rx_vld_d,    rx_vld_q;
  logic                      tx_load_d,   tx_load_q;
  logic                      abort_d,     abort_q;
  logic [XFER_SIZE-1:0]      rx_next;

  // Shift each pin one stage deeper; the history flop trails the last stage.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.i_slave_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.i_slave_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_slave_mosi};
    sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
    cs_hist_d   = cs_sync_q[SYNC_STAGES-1];
  end

  // Synchronizer registers, preset to the bus idle levels (SCLK low, CS_N high).
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes the chain a real pipeline.
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s &  sclk_hist_q;
  assign cs_fall   = ~cs_s   &  cs_hist_q;
  assign cs_rise   =  cs_s   & ~cs_hist_q;
  assign rx_next   = {rx_sr_q, mosi_s};

  // Next-state logic: word framing, shifting, streaming reload and abort.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    word_done_d = word_done_q;
    rx_vld_d    = 1'b0;
    tx_load_d   = 1'b0;
    abort_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // SCLK activity while deselected is ignored.
        if (cs_fall) begin
          tx_sr_d     = bus.i_tx_data;
          tx_load_d   = 1'b1;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          // Deselect wins over a coincident SCLK edge, except that a final
          // rise landing together with it still completes the word.
          state_d     = ST_IDLE;
          word_done_d = 1'b0;
          if (sclk_rise && (bit_cnt_q == LAST_BIT)) begin
            rx_data_d = rx_next;
            rx_vld_d  = 1'b1;
          end else if (bit_cnt_q != '0) begin
            abort_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_sr_d = rx_next[XFER_SIZE-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d   = rx_next;
            rx_vld_d    = 1'b1;
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + XFER_CNT_WIDTH'(1);
          end
        end else if (sclk_fall) begin
          if (word_done_q) begin
            // Back-to-back word under the same CS_N: fetch the next TX word.
            tx_sr_d     = bus.i_tx_data;
            tx_load_d   = 1'b1;
            word_done_d = 1'b0;
          end else begin
            tx_sr_d = {tx_sr_q[XFER_SIZE-2:0], 1'b0};
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Protocol registers; reset discards any partial word and clears pulses.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      // NOTE: the shift registers are reset as well so MISO and o_rx_data
      // never expose stale bits from a word interrupted by reset.
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      word_done_q <= 1'b0;
      rx_vld_q    <= 1'b0;
      tx_load_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      word_done_q <= word_done_d;
      rx_vld_q    <= rx_vld_d;
      tx_load_q   <= tx_load_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.o_tx_load       = tx_load_q;
  assign bus.o_rx_data       = rx_data_q;
  assign bus.o_rx_vld        = rx_vld_q;
  assign bus.o_xfer_abort    = abort_q;
  assign bus.o_busy          = (state_q == ST_SHIFT);
  assign bus.o_slave_miso_oe = (state_q == ST_SHIFT);
  assign bus.o_slave_miso    = (state_q == ST_SHIFT) & tx_sr_q[XFER_SIZE-1];
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave. A behavioural SPI master drives the pins;
// expected RX words, expected MISO words and pulse counts come from queues
// filled by the bench as it generates traffic.
module tb_spi_slave;
  localparam int N    = 32;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.XFER_SIZE(N)) bus ();

  spi_slave #(.XFER_SIZE(N), .SYNC_STAGES(SYNC)) dut (
    .i_sys_clk  (clk),
    .i_sys_rst_n(rst_n),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int n_vld = 0;
  int n_load = 0;
  int n_abort = 0;

  logic [N-1:0] exp_rx_q[$];
  int           rise_cyc_q[$];
  logic [N-1:0] exp_miso_q[$];
  logic [N-1:0] tx_pend_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One system cycle. Outputs are observed on the falling edge; every TX load
  // records the word it captured and presents the next one, every RX valid is
  // scored against the word the master sent and the cycle of its last rise.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (bus.o_tx_load) begin
        n_load++;
        exp_miso_q.push_back(bus.i_tx_data);
        if (tx_pend_q.size() != 0) bus.i_tx_data = tx_pend_q.pop_front();
        else                       bus.i_tx_data = N'($urandom);
      end
      if (bus.o_rx_vld) begin
        n_vld++;
        if (exp_rx_q.size() == 0) begin
          check("rx_vld_expected", bus.o_rx_vld, 1'b0);
        end else begin
          check("rx_data", bus.o_rx_data, exp_rx_q.pop_front());
          check("rx_latency", cyc - rise_cyc_q.pop_front(), LAT);
        end
      end
      if (bus.o_xfer_abort) n_abort++;
    end
  endtask

  function automatic logic [N-1:0] pop_miso();
    if (exp_miso_q.size() == 0) return 'x;
    return exp_miso_q.pop_front();
  endfunction

  task automatic cs_start();
    bus.i_slave_cs_n = 1'b0;
    repeat (2) tick();
  endtask

  task automatic gap();
    repeat (8) tick();
  endtask

  // Shift nbits of wr (MSB first) with h system cycles per SCLK phase.
  // MISO is taken at the end of the high phase: at sys/4 the slave's
  // synchronizer delay exceeds half an SCLK period, so an oversampling master
  // reads late in the phase. With end_cs, CS_N rises together with the last fall.
  task automatic spi_word(input logic [N-1:0] wr, input int nbits, input int h,
                          input bit end_cs, output logic [N-1:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.i_slave_mosi = wr[N-1-i];
      repeat (h) tick();
      if (nbits == N && i == N - 1) begin
        exp_rx_q.push_back(wr);
        rise_cyc_q.push_back(cyc);
      end
      bus.i_slave_sclk = 1'b1;
      rise_cyc = cyc;
      repeat (h) tick();
      rd[N-1-i] = bus.o_slave_miso;
      bus.i_slave_sclk = 1'b0;
      if (end_cs && i == nbits - 1) bus.i_slave_cs_n = 1'b1;
    end
  endtask

  initial begin
    logic [N-1:0] rd, wr, exp, mask, saved;
    int v0, l0, a0;
    logic seen;

    bus.i_tx_data    = '0;
    bus.i_slave_sclk = 1'b0;
    bus.i_slave_cs_n = 1'b1;
    bus.i_slave_mosi = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst_busy",    bus.o_busy,          1'b0);
    check("rst_oe",      bus.o_slave_miso_oe, 1'b0);
    check("rst_miso",    bus.o_slave_miso,    1'b0);
    check("rst_vld",     bus.o_rx_vld,        1'b0);
    check("rst_load",    bus.o_tx_load,       1'b0);
    check("rst_abort",   bus.o_xfer_abort,    1'b0);
    check("rst_rx_data", bus.o_rx_data,       '0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Single word at sys/20.
    v0 = n_vld; l0 = n_load; a0 = n_abort;
    bus.i_tx_data = 32'hDEAD_BEEF;
    cs_start();
    repeat (2) tick();
    check("t1_busy", bus.o_busy,          1'b1);
    check("t1_oe",   bus.o_slave_miso_oe, 1'b1);
    check("t1_msb",  bus.o_slave_miso,    1'b1);
    spi_word(32'hA5A5_3C3C, N, 10, 1'b1, rd);
    check("t1_miso_model", rd, pop_miso());
    check("t1_miso", rd, 32'hDEAD_BEEF);
    gap();
    check("t1_vld_cnt",  n_vld - v0,   1);
    check("t1_load_cnt", n_load - l0,  1);
    check("t1_abort",    n_abort - a0, 0);
    check("t1_rx_data",  bus.o_rx_data, 32'hA5A5_3C3C);
    check("t1_idle_busy", bus.o_busy, 1'b0);

    // Two streamed words under one CS_N; TX word changes after the first load.
    v0 = n_vld; l0 = n_load; a0 = n_abort;
    bus.i_tx_data = 32'hCAFE_F00D;
    tx_pend_q.push_back(32'h0BAD_F00D);
    cs_start();
    spi_word(32'h1234_5678, N, 10, 1'b0, rd);
    check("t2_miso0", rd, pop_miso());
    check("t2_miso0_val", rd, 32'hCAFE_F00D);
    spi_word(32'h9ABC_DEF0, N, 10, 1'b1, rd);
    check("t2_miso1", rd, pop_miso());
    check("t2_miso1_val", rd, 32'h0BAD_F00D);
    gap();
    check("t2_vld_cnt",  n_vld - v0,   2);
    check("t2_load_cnt", n_load - l0,  2);
    check("t2_abort",    n_abort - a0, 0);
    check("t2_rx_data",  bus.o_rx_data, 32'h9ABC_DEF0);

    // Abort after 13 bits.
    v0 = n_vld; l0 = n_load; a0 = n_abort;
    saved = bus.o_rx_data;
    cs_start();
    spi_word(N'($urandom), 13, 10, 1'b1, rd);
    mask = '1;
    mask = ~(mask >> 13);
    exp = pop_miso();
    check("t3_miso_partial", rd & mask, exp & mask);
    gap();
    check("t3_abort_cnt", n_abort - a0, 1);
    check("t3_vld_cnt",   n_vld - v0,   0);
    check("t3_load_cnt",  n_load - l0,  1);
    check("t3_rx_hold",   bus.o_rx_data, saved);
    check("t3_idle_busy", bus.o_busy, 1'b0);
    check("t3_idle_oe",   bus.o_slave_miso_oe, 1'b0);

    // Reset after 20 bits, then a fresh word.
    cs_start();
    spi_word(N'($urandom), 20, 10, 1'b0, rd);
    rst_n = 1'b0;
    tick();
    check("t4_rst_busy",  bus.o_busy,          1'b0);
    check("t4_rst_oe",    bus.o_slave_miso_oe, 1'b0);
    check("t4_rst_miso",  bus.o_slave_miso,    1'b0);
    check("t4_rst_vld",   bus.o_rx_vld,        1'b0);
    check("t4_rst_load",  bus.o_tx_load,       1'b0);
    check("t4_rst_abort", bus.o_xfer_abort,    1'b0);
    check("t4_rst_rx",    bus.o_rx_data,       '0);
    bus.i_slave_cs_n = 1'b1;
    bus.i_slave_sclk = 1'b0;
    exp_miso_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    v0 = n_vld; l0 = n_load; a0 = n_abort;
    wr = N'($urandom);
    cs_start();
    spi_word(wr, N, 10, 1'b1, rd);
    check("t4_miso", rd, pop_miso());
    gap();
    check("t4_vld_cnt",  n_vld - v0,   1);
    check("t4_load_cnt", n_load - l0,  1);
    check("t4_abort",    n_abort - a0, 0);
    check("t4_rx_data",  bus.o_rx_data, wr);

    // SCLK activity while deselected.
    v0 = n_vld; l0 = n_load; a0 = n_abort;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.i_slave_sclk = ~bus.i_slave_sclk;
      bus.i_slave_mosi = 1'($urandom);
      repeat (3) tick();
      seen = seen | bus.o_busy | bus.o_slave_miso_oe | bus.o_slave_miso;
    end
    gap();
    check("t5_quiet_pins", seen, 1'b0);
    check("t5_pulses", (n_vld - v0) + (n_load - l0) + (n_abort - a0), 0);

    // Final rise coincident with CS_N release still completes the word.
    v0 = n_vld; l0 = n_load; a0 = n_abort;
    wr = N'($urandom);
    cs_start();
    spi_word(wr, N - 1, 10, 1'b0, rd);
    bus.i_slave_mosi = wr[0];
    repeat (10) tick();
    exp_rx_q.push_back(wr);
    rise_cyc_q.push_back(cyc);
    bus.i_slave_sclk = 1'b1;
    bus.i_slave_cs_n = 1'b1;
    repeat (10) tick();
    bus.i_slave_sclk = 1'b0;
    exp = pop_miso();
    check("t7_miso_partial", rd[N-1:1], exp[N-1:1]);
    gap();
    check("t7_vld_cnt", n_vld - v0,   1);
    check("t7_abort",   n_abort - a0, 0);
    check("t7_rx_data", bus.o_rx_data, wr);

    // Random bursts of 1..4 words at the maximum SCLK rate (sys/4).
    v0 = n_vld; l0 = n_load; a0 = n_abort;
    begin
      int left;
      int nw;
      left = 300;
      while (left > 0) begin
        nw = int'($urandom_range(1, 4));
        if (nw > left) nw = left;
        cs_start();
        for (int w = 0; w < nw; w++) begin
          wr = N'($urandom);
          spi_word(wr, N, 2, (w == nw - 1), rd);
          check("t6_miso", rd, pop_miso());
        end
        gap();
        left -= nw;
      end
    end
    check("t6_vld_cnt",  n_vld - v0,   300);
    check("t6_load_cnt", n_load - l0,  300);
    check("t6_abort",    n_abort - a0, 0);

    check("end_rx_queue",   exp_rx_q.size(),   0);
    check("end_miso_queue", exp_miso_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
